// File: rtl/xor_parity_frame_pkg.sv
// Shared types, constants and the parity reduction helper for the streaming
// parity generator/checker.
package xor_parity_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   localparam logic MODE_GEN = 1'b0;
   localparam logic MODE_CHK = 1'b1;

   // Widest beat the reduction helper handles; narrower beats are zero-extended,
   // which does not change the XOR result.
   localparam int XR_MAX_W = 256;

   // XOR of the low w bits of v.
   function automatic logic xor_reduce_w(input logic [XR_MAX_W-1:0] v, input int w);
      logic r;
      r = 1'b0;
      for (int i = 0; i < XR_MAX_W; i++) begin
         if (i < w) r = r ^ v[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/xor_parity_frame_xor_reduce.sv
// Combinational XOR reduction of one WIDTH-bit beat (WIDTH up to XR_MAX_W).
module xor_parity_frame_xor_reduce
   import xor_parity_frame_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   output logic             par
);

   logic [XR_MAX_W-1:0] ext;

   // Zero-extend the beat and fold it down to a single parity bit.
   always_comb begin
      ext              = '0;
      ext[WIDTH-1:0]   = data;
      par              = xor_reduce_w(ext, WIDTH);
   end

endmodule

// File: rtl/xor_parity_frame.sv
// Streaming frame parity generator/checker: accumulates per-beat parity over a
// frame closed by in_last (or forced closed at MAX_LEN beats) and presents one
// held result per frame.
module xor_parity_frame
   import xor_parity_frame_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter int   MAX_LEN    = 16,
   parameter logic ODD_PARITY = 1'b0,
   localparam int  LW         = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             in_par,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_par,
   output logic             out_err,
   output logic             out_len_err,
   output logic [LW-1:0]    out_len
);

   state_t          state_reg, state_next;
   logic            acc_reg;
   logic [LW-1:0]   cnt_reg;
   logic            mode_reg;
   logic            par_reg;
   logic            len_err_reg;

   logic            word_par;
   logic            accept;
   logic [LW-1:0]   cnt_next;
   logic            close;
   logic            frame_par;
   logic            in_result;

   xor_parity_frame_xor_reduce #(
      .WIDTH (WIDTH)
   ) u_xor_reduce (
      .data (in_data),
      .par  (word_par)
   );

   // Beat accounting: the first beat of a frame restarts the count at one.
   always_comb begin
      accept   = in_valid & in_ready;
      cnt_next = (state_reg == ST_IDLE) ? LW'(1) : cnt_reg + LW'(1);
      close    = in_last | (cnt_next == LW'(MAX_LEN));
   end

   // State register; reset discards any frame in progress or pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state: close on in_last or the MAX_LEN-th beat, drain on out_ready.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_ACCUM: begin
            if (accept) state_next = close ? ST_RESULT : ST_ACCUM;
         end
         ST_RESULT: begin
            if (out_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Frame datapath: parity accumulator, beat count and sampled mode/parity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg     <= 1'b0;
         cnt_reg     <= '0;
         mode_reg    <= MODE_GEN;
         par_reg     <= 1'b0;
         len_err_reg <= 1'b0;
      end else if (accept) begin
         if (state_reg == ST_IDLE) begin
            acc_reg  <= word_par;
            mode_reg <= mode;
         end else begin
            acc_reg  <= acc_reg ^ word_par;
         end
         cnt_reg <= cnt_next;
         if (close) begin
            par_reg     <= in_par;
            // Closing without in_last can only mean the length limit was hit.
            len_err_reg <= ~in_last;
         end
      end
   end

   // Outputs are decoded from registers only and forced to zero outside RESULT.
   always_comb begin
      in_result   = (state_reg == ST_RESULT);
      frame_par   = acc_reg ^ ODD_PARITY;
      in_ready    = rst_n & ~in_result;
      out_valid   = in_result;
      out_par     = in_result & frame_par;
      out_err     = in_result & (mode_reg == MODE_CHK) & ~len_err_reg & (frame_par != par_reg);
      out_len_err = in_result & len_err_reg;
      out_len     = in_result ? cnt_reg : '0;
   end

endmodule

// File: tb/tb_xor_parity_frame.sv
// Directed bench for xor_parity_frame: one even-parity instance with a short
// frame limit and one odd-parity instance, sharing clock and reset.
module tb_xor_parity_frame;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Instance A: WIDTH=8, MAX_LEN=4, even parity.
   logic       mode_a = 1'b0, valid_a = 1'b0, last_a = 1'b0, par_in_a = 1'b0, oready_a = 1'b0;
   logic [7:0] data_a = 8'h00;
   logic       ready_a, ovalid_a, opar_a, oerr_a, olenerr_a;
   logic [2:0] olen_a;

   // Instance B: WIDTH=8, MAX_LEN=16, odd parity.
   logic       mode_b = 1'b0, valid_b = 1'b0, last_b = 1'b0, par_in_b = 1'b0, oready_b = 1'b0;
   logic [7:0] data_b = 8'h00;
   logic       ready_b, ovalid_b, opar_b, oerr_b, olenerr_b;
   logic [4:0] olen_b;

   int total = 0;
   int bad = 0;

   xor_parity_frame #(.WIDTH(8), .MAX_LEN(4), .ODD_PARITY(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .mode(mode_a), .in_valid(valid_a), .in_ready(ready_a),
      .in_data(data_a), .in_last(last_a), .in_par(par_in_a), .out_valid(ovalid_a),
      .out_ready(oready_a), .out_par(opar_a), .out_err(oerr_a), .out_len_err(olenerr_a),
      .out_len(olen_a)
   );

   xor_parity_frame #(.WIDTH(8), .MAX_LEN(16), .ODD_PARITY(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .mode(mode_b), .in_valid(valid_b), .in_ready(ready_b),
      .in_data(data_b), .in_last(last_b), .in_par(par_in_b), .out_valid(ovalid_b),
      .out_ready(oready_b), .out_par(opar_b), .out_err(oerr_b), .out_len_err(olenerr_b),
      .out_len(olen_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one beat on A and hold it until accepted (bounded wait).
   task automatic send_a(input logic [7:0] d, input logic l, input logic m, input logic p);
      int n;
      n = 0;
      data_a = d; last_a = l; mode_a = m; par_in_a = p; valid_a = 1'b1;
      while (!ready_a && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("send_a_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      valid_a = 1'b0; data_a = 'x; last_a = 1'b0;
   endtask

   task automatic drain_a();
      oready_a = 1'b1;
      @(posedge clk); #1;
      oready_a = 1'b0;
   endtask

   task automatic chk_res_a(input string tag, input logic p, input logic e, input logic le,
                            input logic [2:0] len);
      $display("frame %s: valid=%0b par=%0b err=%0b len_err=%0b len=%0d",
               tag, ovalid_a, opar_a, oerr_a, olenerr_a, olen_a);
      chk({tag, "_valid"}, 32'(ovalid_a), 32'd1);
      chk({tag, "_par"}, 32'(opar_a), 32'(p));
      chk({tag, "_err"}, 32'(oerr_a), 32'(e));
      chk({tag, "_lenerr"}, 32'(olenerr_a), 32'(le));
      chk({tag, "_len"}, 32'(olen_a), 32'(len));
      chk({tag, "_inready"}, 32'(ready_a), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #2;
      chk("rst_ready_a", 32'(ready_a), 32'd0);
      chk("rst_valid_a", 32'(ovalid_a), 32'd0);
      chk("rst_par_a", 32'(opar_a), 32'd0);
      chk("rst_err_a", 32'(oerr_a), 32'd0);
      chk("rst_lenerr_a", 32'(olenerr_a), 32'd0);
      chk("rst_len_a", 32'(olen_a), 32'd0);
      chk("rst_par_b", 32'(opar_b), 32'd0);
      chk("rst_ready_b", 32'(ready_b), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_ready_a", 32'(ready_a), 32'd1);

      // 1: generate, A5 / 01 / FF(last) with idle X cycles mid-frame -> par 1, len 3
      send_a(8'hA5, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("t1_mid_valid", 32'(ovalid_a), 32'd0);
      send_a(8'h01, 1'b0, 1'b0, 1'b0);
      send_a(8'hFF, 1'b1, 1'b0, 1'b1);
      chk_res_a("t1", 1'b1, 1'b0, 1'b0, 3'd3);
      drain_a();
      chk("t1_drained_valid", 32'(ovalid_a), 32'd0);
      chk("t1_drained_ready", 32'(ready_a), 32'd1);

      // 2: check mode, 03 last, in_par=1 -> par 0 err 1; in_par=0 -> err 0
      send_a(8'h03, 1'b1, 1'b1, 1'b1);
      chk_res_a("t2a", 1'b0, 1'b1, 1'b0, 3'd1);
      drain_a();
      send_a(8'h03, 1'b1, 1'b1, 1'b0);
      chk_res_a("t2b", 1'b0, 1'b0, 1'b0, 3'd1);
      drain_a();
      // mode latched on first beat; mode drop on the last beat is ignored
      send_a(8'h03, 1'b0, 1'b1, 1'b0);
      send_a(8'h00, 1'b1, 1'b0, 1'b1);
      chk_res_a("t2c", 1'b0, 1'b1, 1'b0, 3'd2);
      drain_a();

      // 4: forced close at MAX_LEN=4, check-mode error suppressed
      send_a(8'h01, 1'b0, 1'b1, 1'b0);
      send_a(8'h01, 1'b0, 1'b0, 1'b0);
      send_a(8'h01, 1'b0, 1'b0, 1'b0);
      send_a(8'h01, 1'b0, 1'b0, 1'b1);
      chk_res_a("t4", 1'b0, 1'b0, 1'b1, 3'd4);
      // beat 5 waits while the result is pending
      data_a = 8'h07; last_a = 1'b1; mode_a = 1'b0; par_in_a = 1'b0; valid_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("t4_stall_ready", 32'(ready_a), 32'd0);
         chk("t4_stall_len", 32'(olen_a), 32'd4);
      end
      oready_a = 1'b1;
      @(posedge clk); #1;
      oready_a = 1'b0;
      chk("t4_drain_valid", 32'(ovalid_a), 32'd0);
      chk("t4_drain_ready", 32'(ready_a), 32'd1);
      @(posedge clk); #1;
      valid_a = 1'b0; last_a = 1'b0; data_a = 'x;
      chk_res_a("t4_beat5", 1'b1, 1'b0, 1'b0, 3'd1);
      drain_a();

      // last on the MAX_LEN-th beat is a normal close
      send_a(8'h80, 1'b0, 1'b0, 1'b0);
      send_a(8'h80, 1'b0, 1'b0, 1'b0);
      send_a(8'h80, 1'b0, 1'b0, 1'b0);
      send_a(8'h80, 1'b1, 1'b0, 1'b0);
      chk_res_a("t4_lastmax", 1'b0, 1'b0, 1'b0, 3'd4);
      drain_a();

      // 5: result held 5 cycles with out_ready low
      send_a(8'h01, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk_res_a("t5_hold", 1'b1, 1'b0, 1'b0, 3'd1);
      end
      drain_a();
      chk("t5_release_ready", 32'(ready_a), 32'd1);
      send_a(8'h0E, 1'b1, 1'b0, 1'b0);
      chk_res_a("t5_next", 1'b1, 1'b0, 1'b0, 3'd1);
      drain_a();

      // 3: odd parity instance, single beat 00 -> par 1, valid one cycle after accept
      data_b = 8'h00; last_b = 1'b1; mode_b = 1'b0; valid_b = 1'b1;
      #2;
      chk("t3_pre_valid", 32'(ovalid_b), 32'd0);
      @(posedge clk); #1;
      valid_b = 1'b0;
      $display("frame t3: valid=%0b par=%0b len=%0d", ovalid_b, opar_b, olen_b);
      chk("t3_valid", 32'(ovalid_b), 32'd1);
      chk("t3_par", 32'(opar_b), 32'd1);
      chk("t3_len", 32'(olen_b), 32'd1);
      chk("t3_err", 32'(oerr_b), 32'd0);
      oready_b = 1'b1;
      @(posedge clk); #1;
      oready_b = 1'b0;
      chk("t3_drain_valid", 32'(ovalid_b), 32'd0);
      data_b = 8'h01; valid_b = 1'b1;
      @(posedge clk); #1;
      valid_b = 1'b0;
      $display("frame t3b: valid=%0b par=%0b len=%0d", ovalid_b, opar_b, olen_b);
      chk("t3b_par", 32'(opar_b), 32'd0);
      oready_b = 1'b1;
      @(posedge clk); #1;
      oready_b = 1'b0;

      // 6: async reset mid-frame discards it
      send_a(8'h01, 1'b0, 1'b0, 1'b0);
      send_a(8'h01, 1'b0, 1'b0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ready", 32'(ready_a), 32'd0);
      chk("t6_rst_valid", 32'(ovalid_a), 32'd0);
      chk("t6_rst_len", 32'(olen_a), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("t6_no_result", 32'(ovalid_a), 32'd0);
         chk("t6_idle_ready", 32'(ready_a), 32'd1);
      end
      send_a(8'h0F, 1'b1, 1'b0, 1'b0);
      chk_res_a("t6_after", 1'b0, 1'b0, 1'b0, 3'd1);
      drain_a();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
